seq_divider4: RTL and testbench

SEQ_DIVIDER4 -- requirements
Module: seq_divider4

---
 rtl/seq_divider4.sv | 151 +++++++++++++++
 tb/tb_seq_divider4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider4.sv
// seq_divider4: unsigned restoring divider, one quotient bit per clock.
//
// Handshake: a request is taken when start=1 at a rising edge while the
// block is idle. Operands are captured on that edge and are never looked at
// again. The result is valid, and quotient/remainder/div_by_zero are
// meaningful, only in the single cycle where done=1. start is ignored at
// every other time. busy=1 marks the iteration cycles. busy and done are
// never high together. quotient and remainder keep their last result until
// the next completion.
//
// The partial remainder A is WIDTH bits wide. The shifted value {A, Q msb}
// is WIDTH+1 bits wide, so the trial subtraction cannot overflow. Because
// A < divisor holds before each shift, the shifted value is below
// 2*divisor. After a successful subtraction, A is again below divisor.
module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERATIONS = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic             dz_flag;

  logic [WIDTH:0]   shift_a;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // One restoring step: shift {A,Q} left, subtract divisor, keep or restore.
  always_comb begin
    shift_a   = {a, q[WIDTH-1]};
    trial     = shift_a + {1'b1, ~d} + (WIDTH+1)'(1);
    borrow    = trial[WIDTH];
    a_next    = borrow ? shift_a[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next    = {q[WIDTH-2:0], ~borrow};
    last_iter = (count == CW'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        div_by_zero = dz_flag;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dz_flag   <= 1'b1;
            end else begin
              a     <= '0;
              q     <= dividend;
              d     <= divisor;
              count <= ITERATIONS;
            end
          end
        end
        RUN: begin
          a     <= a_next;
          q     <= q_next;
          count <= count - CW'(1);
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= a_next;
          end
        end
        DONE: begin
          dz_flag <= 1'b0;
        end
        default: begin
          dz_flag <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_seq_divider4.sv
// tb_seq_divider4: directed vector table plus hand-written multi-cycle
// sequences for the seq_divider4 restoring divider.
module tb_seq_divider4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] ds;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[11];

  // Clock.
  always #5 clk = ~clk;

  seq_divider4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .fsm_state  (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // The first rising edge after the caller returns from its own negedge is t0.
  // The task samples on each falling edge until done is seen or the budget
  // runs out. When the sample count equals pulse_at, it drives a stray start
  // with different operands for one cycle.
  task automatic wait_done(input string tag, input int pulse_at, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      check({tag, "_busy_done_overlap"}, busy & done, 0);
      if (busy) bcnt++;
      if (done) break;
      if (lat == pulse_at) begin
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
      end else if (lat == pulse_at + 1) begin
        start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic check_result(input string tag, input int lat, input int bcnt,
                              input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    check({tag, "_latency"}, lat, ez ? 1 : 5);
    check({tag, "_busy_cycles"}, bcnt, ez ? 0 : 4);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_by_zero"}, div_by_zero, ez);
  endtask

  // Launch one division. Operands are scrambled right after t0. After the
  // done cycle, the task checks that the strobe fell and the result holds.
  task automatic run_vec(input string tag, input vec_t v);
    int lat, bcnt;
    @(negedge clk);
    dividend = v.dd;
    divisor  = v.ds;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom_range(0, 15));
    divisor  = W'($urandom_range(0, 15));
    wait_done(tag, -1, lat, bcnt);
    check_result(tag, lat, bcnt, v.exp_q, v.exp_r, v.exp_dz);
    @(negedge clk);
    check({tag, "_done_low_after"}, done, 0);
    check({tag, "_dz_low_after"}, div_by_zero, 0);
    check({tag, "_quotient_hold"}, quotient, v.exp_q);
    check({tag, "_remainder_hold"}, remainder, v.exp_r);
  endtask

  initial begin
    int lat, bcnt, seen;
    vec_t v;

    vecs[0]  = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
    vecs[1]  = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    vecs[2]  = '{4'd5,  4'd7,  4'd0,  4'd5,  1'b0};
    vecs[3]  = '{4'd0,  4'd4,  4'd0,  4'd0,  1'b0};
    vecs[4]  = '{4'd9,  4'd0,  4'd15, 4'd9,  1'b1};
    vecs[5]  = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    vecs[6]  = '{4'd14, 4'd15, 4'd0,  4'd14, 1'b0};
    vecs[7]  = '{4'd15, 4'd2,  4'd7,  4'd1,  1'b0};
    vecs[8]  = '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1};
    vecs[9]  = '{4'd11, 4'd4,  4'd2,  4'd3,  1'b0};
    vecs[10] = '{4'd15, 4'd8,  4'd1,  4'd7,  1'b0};

    // Reset with start asserted: reset must win.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", fsm_state, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", div_by_zero, 0);

    // Start held through reset release: the first edge after release is t0.
    rst = 1'b0;
    wait_done("first_after_reset", -1, lat, bcnt);
    start = 1'b0;
    check_result("first_after_reset", lat, bcnt, 4'd4, 4'd1, 1'b0);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Stray start with other operands during RUN is ignored.
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("start_in_run", 2, lat, bcnt);
    start = 1'b0;
    check_result("start_in_run", lat, bcnt, 4'd3, 4'd0, 1'b0);

    // Reset in the second RUN cycle discards the division.
    @(negedge clk);
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("midrun_busy_before_rst", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_state", fsm_state, 0);
    check("midrun_rst_quotient", quotient, 0);
    check("midrun_rst_remainder", remainder, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrun_no_done_after_rst", seen, 0);
    v = '{4'd12, 4'd5, 4'd2, 4'd2, 1'b0};
    run_vec("after_midrun_rst", v);

    // Start held high: one result every 6 cycles. Start in DONE is ignored.
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    wait_done("held0", -1, lat, bcnt);
    check_result("held0", lat, bcnt, 4'd3, 4'd2, 1'b0);
    for (int k = 1; k < 3; k++) begin
      wait_done($sformatf("held%0d", k), -1, lat, bcnt);
      check($sformatf("held%0d_period", k), lat, 6);
      check($sformatf("held%0d_busy_cycles", k), bcnt, 4);
      check($sformatf("held%0d_quotient", k), quotient, 4'd3);
      check($sformatf("held%0d_remainder", k), remainder, 4'd2);
    end
    start = 1'b0;
    @(negedge clk);
    check("held_idle_after", fsm_state, 0);
    check("held_quotient_hold", quotient, 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
